// File: rtl/polyvec_out_collector.sv
// Collects coefficient pairs from the basemul/accumulate stage in any order, then
// streams them out in index order, reduced to the canonical range [0, KYBER_Q-1].
module polyvec_out_collector #(
   parameter int DEPTH   = 5,
   parameter int KYBER_Q = 3329
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [15:0]      polyvec_dout_1,
   input  logic signed [15:0]      polyvec_dout_2,
   input  logic        [DEPTH-1:0] out_index,
   input  logic                    done,
   output logic                    readout,
   output logic                    full,
   input  logic                    rd_en,
   output logic        [15:0]      rd_data,
   output logic        [DEPTH-1:0] rd_index,
   output logic                    rd_valid,
   output logic                    rd_last,
   output logic                    err_dup,
   output logic                    err_odd
);

   localparam int N     = 1 << DEPTH;
   localparam int PAIRS = N / 2;
   localparam int PW    = DEPTH - 1;
   localparam int BARRETT_V = ((1 << 26) + KYBER_Q / 2) / KYBER_Q;
   localparam logic signed [31:0] BARRETT_V_S = 32'(BARRETT_V);
   localparam logic signed [31:0] Q_S         = 32'(KYBER_Q);
   localparam logic signed [31:0] ROUND_S     = 32'sd33554432;

   typedef enum logic [1:0] {COLLECT, FULL, DRAIN} state_t;

   state_t             state_reg, state_next;
   logic [PAIRS-1:0]   bitmap_reg, bitmap_next, pair_onehot;
   logic [DEPTH-1:0]   ptr_reg, ptr_next;
   logic               readout_reg, full_reg;
   logic               rd_valid_reg, rd_last_reg;
   logic [15:0]        rd_data_reg;
   logic [DEPTH-1:0]   rd_index_reg;
   logic               err_dup_reg, err_odd_reg;

   // Stored as two half-buffers so a whole pair is written in one cycle.
   logic signed [15:0] mem_lo [PAIRS];
   logic signed [15:0] mem_hi [PAIRS];

   logic [PW-1:0]      pair_idx;
   logic               accept, accept_even, issue;
   logic signed [15:0] rd_word;
   logic signed [31:0] x_ext, barrett_prod, barrett_t, barrett_r, barrett_adj;
   logic [15:0]        reduced;

   assign pair_idx    = out_index[DEPTH-1:1];
   assign accept      = readout_reg && done;
   assign accept_even = accept && !out_index[0];
   // Once the last coefficient has been issued, the following cycle only tidies up.
   assign issue       = rd_en && ((state_reg == FULL) || ((state_reg == DRAIN) && !rd_last_reg));

   generate
      for (genvar gi = 0; gi < PAIRS; gi++) begin : g_onehot
         assign pair_onehot[gi] = (pair_idx == PW'(gi));
      end
   endgenerate

   always_comb begin
      state_next  = state_reg;
      bitmap_next = bitmap_reg;
      ptr_next    = ptr_reg;
      case (state_reg)
         COLLECT: begin
            if (accept_even) begin
               bitmap_next = bitmap_reg | pair_onehot;
               if (&bitmap_next) state_next = FULL;
            end
         end
         FULL: begin
            if (issue) begin
               state_next = DRAIN;
               ptr_next   = ptr_reg + 1'b1;
            end
         end
         DRAIN: begin
            if (rd_last_reg) begin
               state_next  = COLLECT;
               bitmap_next = '0;
               ptr_next    = '0;
            end else if (issue) begin
               ptr_next = ptr_reg + 1'b1;
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   // Barrett estimate leaves a centred remainder; one correction makes it canonical.
   always_comb begin
      rd_word      = ptr_reg[0] ? mem_hi[ptr_reg[DEPTH-1:1]] : mem_lo[ptr_reg[DEPTH-1:1]];
      x_ext        = {{16{rd_word[15]}}, rd_word};
      barrett_prod = BARRETT_V_S * x_ext + ROUND_S;
      barrett_t    = barrett_prod >>> 26;
      barrett_r    = x_ext - barrett_t * Q_S;
      barrett_adj  = barrett_r;
      if (barrett_r < 0)
         barrett_adj = barrett_r + Q_S;
      else if (barrett_r >= Q_S)
         barrett_adj = barrett_r - Q_S;
      reduced = 16'(barrett_adj);
   end

   always_ff @(posedge clk) begin
      if (accept_even) begin
         mem_lo[pair_idx] <= polyvec_dout_1;
         mem_hi[pair_idx] <= polyvec_dout_2;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= COLLECT;
         bitmap_reg   <= '0;
         ptr_reg      <= '0;
         readout_reg  <= 1'b0;
         full_reg     <= 1'b0;
         rd_valid_reg <= 1'b0;
         rd_last_reg  <= 1'b0;
         rd_data_reg  <= '0;
         rd_index_reg <= '0;
         err_dup_reg  <= 1'b0;
         err_odd_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bitmap_reg   <= bitmap_next;
         ptr_reg      <= ptr_next;
         readout_reg  <= (state_next == COLLECT);
         full_reg     <= (state_next != COLLECT);
         rd_valid_reg <= issue;
         rd_last_reg  <= issue && (&ptr_reg);
         if (issue) begin
            rd_data_reg  <= reduced;
            rd_index_reg <= ptr_reg;
         end
         if (accept) begin
            if (out_index[0])
               err_odd_reg <= 1'b1;
            else if (|(bitmap_reg & pair_onehot))
               err_dup_reg <= 1'b1;
         end
      end
   end

   assign readout  = readout_reg;
   assign full     = full_reg;
   assign rd_valid = rd_valid_reg;
   assign rd_last  = rd_last_reg;
   assign rd_data  = rd_data_reg;
   assign rd_index = rd_index_reg;
   assign err_dup  = err_dup_reg;
   assign err_odd  = err_odd_reg;

endmodule

// File: doc/polyvec_out_collector.md
Name: polyvec_out_collector

Overview:
- Receiving end of the polyvec_basemul_acc_mont output stream.
- Accepts coefficient pairs (polyvec_dout_1/2 at out_index) under a readout/done handshake, in any order, into an internal 2^DEPTH-entry buffer.
- Tracks which pairs have arrived and declares the polynomial complete.
- Then streams the coefficients out in index order, reduced to canonical [0, 3328] mod q = 3329, for the next stage (pack/compress).

Parameters:
- DEPTH, 5, log2 of coefficients per polynomial (N = 2^DEPTH; pairs = N/2).
- KYBER_Q, 3329, modulus used by the output reduction.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- polyvec_dout_1  input  16  signed coefficient at out_index.
- polyvec_dout_2  input  16  signed coefficient at out_index+1.
- out_index  input  DEPTH  index of the pair's first coefficient; must be even.
- done  input  1  producer strobe: the current pair is valid.
- readout  output  1  collector ready to accept a pair.
- full  output  1  all N/2 pairs received; buffer frozen.
- rd_en  input  1  downstream request for the next coefficient.
- rd_data  output  16  reduced coefficient, range 0..3328.
- rd_index  output  DEPTH  index of rd_data.
- rd_valid  output  1  rd_data/rd_index valid this cycle.
- rd_last  output  1  qualifies the final coefficient (index N-1).
- err_dup  output  1  sticky: a pair index was received twice in one fill.
- err_odd  output  1  sticky: a pair arrived with odd out_index.

Behaviour:
- Reset (reset=0, asynchronous):
  - State COLLECT; received bitmap cleared; read pointer 0.
  - readout=0 while reset is asserted, then 1 on the first clock after release.
  - full=0, rd_valid=0, rd_last=0, rd_data=0, rd_index=0, err_dup=0, err_odd=0.
  - Buffer contents are don't-care.
- States: COLLECT -> FULL -> DRAIN -> COLLECT.
- COLLECT:
  - readout=1.
  - Pair accepted on a rising edge where readout=1 and done=1: mem[out_index] <= dout_1, mem[out_index+1] <= dout_2, bitmap[out_index>>1] <= 1.
  - Duplicate index (bit already set): data is overwritten and err_dup is set.
  - Odd out_index: pair is dropped, bitmap unchanged, err_odd is set.
  - When the accepted pair sets the last clear bit, go to FULL. full=1 and readout=0 from the next cycle.
  - done while readout=0 is ignored. The producer holds the pair until it sees readout.
- FULL:
  - Buffer frozen; no new pairs accepted.
  - The first cycle with rd_en=1 issues coefficient 0 and moves to DRAIN.
- DRAIN:
  - Each cycle with rd_en=1 issues mem[ptr], then ptr++.
  - Output is registered: rd_valid, rd_data and rd_index appear the cycle after rd_en. Throughput is one coefficient per cycle.
  - rd_en=0 stalls; rd_valid=0 on the following cycle and ptr holds.
  - rd_last=1 together with rd_index = N-1.
  - The cycle after ptr N-1 is issued: bitmap cleared, ptr=0, full=0, state COLLECT. readout=1 from the cycle after rd_last.
  - rd_en outside FULL/DRAIN is ignored.
- Reduction:
  - rd_data = x mod KYBER_Q, where x is the stored 16-bit signed value, always in [0, 3328].
  - Implementation: Barrett (v = 20159, (v*x + 2^25) >>> 26), then conditional add/subtract of q. This sits in the same cycle as the output register.
- Sticky errors: cleared only by reset. They do not block operation.
- Reset mid-collect or mid-drain: all progress is discarded; the next fill starts from an empty bitmap.

Test Plan:
- In-order fill, DEPTH=5: pairs at indices 0,2,...,30 with dout_1=idx, dout_2=idx+1, one per cycle -> full=1 one cycle after the 16th accept. Hold rd_en=1 -> rd_data 0..31 on consecutive cycles, rd_last with rd_index=31, readout=1 the next cycle.
- Out-of-order fill: indices 30,0,14,2,... (all 16, shuffled), with done idle gaps -> full only after the 16th distinct pair. Drain returns values in index order.
- Reduction boundaries: store -1, 3329, -32768, 32767, 3328, 0 -> rd_data = 3328, 0, 522, 2806, 3328, 0.
- Errors: out_index=4 sent twice with values 7 then 9 -> err_dup=1, drained value at index 4 is 9, full not premature. out_index=3 -> err_odd=1, bitmap unchanged.
- Stall and backpressure: rd_en toggled 1,0,1 during drain -> no skipped or repeated index. done=1 while full=1 -> ignored, buffer unchanged.
- Reset: assert reset after 10 accepts -> outputs return to reset values immediately. A subsequent full 16-pair fill completes normally with correct data.
